// File: rtl/deco_4x16_reg.sv
// 4-to-16 one-hot timing-step decoder (T0..T15) for the sequence counter.
// Provides a zero-latency combinational decode and a registered, clearable copy.
module deco_4x16_reg #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [SEL_W-1:0] select,
    output logic [OUT_W-1:0] decoded_op,
    output logic [OUT_W-1:0] decoded_q
);

    // Power-up value matches the cleared state so the timing lines start quiet.
    logic [OUT_W-1:0] q_reg = '0;

    // Equality against each index: an X/Z select never compares true,
    // so no timing line can be asserted spuriously.
    always_comb begin
        decoded_op = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (select == SEL_W'(i)) begin
                decoded_op[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_reg <= '0;
        end else begin
            q_reg <= decoded_op;
        end
    end

    assign decoded_q = q_reg;

endmodule

// File: tb/tb_deco_4x16_reg.sv
// Self-checking bench for deco_4x16_reg: table-driven vectors plus hand-written
// sequences, with registered outputs checked through an expected-value queue.
module tb_deco_4x16_reg;

    typedef struct {
        logic [3:0]  sel;
        logic        clr;
        logic [15:0] exp_op;
        logic [15:0] exp_q;
    } vec_t;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [3:0]  select;
    logic [15:0] decoded_op;
    logic [15:0] decoded_q;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q_fifo[$];
    vec_t        vecs[$];

    deco_4x16_reg #(.SEL_W(4), .OUT_W(16)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .select     (select),
        .decoded_op (decoded_op),
        .decoded_q  (decoded_q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] onehot(input int idx);
        logic [15:0] one;
        one = 16'h0001;
        return one << idx;
    endfunction

    task automatic compare16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Pops the oldest expected register value and checks the one-hot invariant.
    task automatic check_output(input string name);
        logic [15:0] req;
        checks++;
        if (exp_q_fifo.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, got %h, expected a queued value", name, decoded_q);
        end else begin
            req = exp_q_fifo.pop_front();
            if (decoded_q !== req) begin
                failures++;
                $display("[TB] FAIL %s: decoded_q got %h, expected %h", name, decoded_q, req);
            end
        end
        checks++;
        if ($countones(decoded_q) > 1 || $isunknown(decoded_q)) begin
            failures++;
            $display("[TB] FAIL %s onehot: decoded_q got %h, expected popcount <= 1", name, decoded_q);
        end
    endtask

    // Drives one cycle: checks the combinational decode, then the register after the edge.
    task automatic apply_stimulus(input string name, input logic [3:0] sel, input logic clr,
                                  input logic [15:0] exp_op, input logic [15:0] exp_q);
        select = sel;
        CLR    = clr;
        #1;
        compare16({name, " decoded_op"}, decoded_op, exp_op);
        exp_q_fifo.push_back(exp_q);
        @(posedge CLK);
        #1;
        check_output(name);
    endtask

    initial begin
        logic [15:0] unk_exp;
        logic [3:0]  cnt;

        CLR    = 1'b1;
        select = 4'd0;
        #1;
        compare16("power_up", decoded_q, 16'h0000);
        @(posedge CLK);
        #1;
        compare16("initial_reset", decoded_q, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{sel: 4'(i), clr: 1'b0, exp_op: onehot(i), exp_q: onehot(i)});
        end
        vecs.push_back('{sel: 4'd9,  clr: 1'b0, exp_op: 16'h0200, exp_q: 16'h0200});
        vecs.push_back('{sel: 4'd5,  clr: 1'b1, exp_op: 16'h0020, exp_q: 16'h0000});
        vecs.push_back('{sel: 4'd5,  clr: 1'b1, exp_op: 16'h0020, exp_q: 16'h0000});
        vecs.push_back('{sel: 4'd5,  clr: 1'b0, exp_op: 16'h0020, exp_q: 16'h0020});
        vecs.push_back('{sel: 4'd14, clr: 1'b0, exp_op: 16'h4000, exp_q: 16'h4000});
        vecs.push_back('{sel: 4'd15, clr: 1'b0, exp_op: 16'h8000, exp_q: 16'h8000});
        vecs.push_back('{sel: 4'd0,  clr: 1'b0, exp_op: 16'h0001, exp_q: 16'h0001});
        vecs.push_back('{sel: 4'd7,  clr: 1'b0, exp_op: 16'h0080, exp_q: 16'h0080});
        vecs.push_back('{sel: 4'd7,  clr: 1'b1, exp_op: 16'h0080, exp_q: 16'h0000});
        vecs.push_back('{sel: 4'd3,  clr: 1'b0, exp_op: 16'h0008, exp_q: 16'h0008});

        foreach (vecs[k]) begin
            apply_stimulus($sformatf("vec%0d", k), vecs[k].sel, vecs[k].clr,
                           vecs[k].exp_op, vecs[k].exp_q);
        end

        // A 2-state simulator resolves the X bits, so expect the decode of whatever it holds.
        select = 4'bx1x0;
        CLR    = 1'b0;
        #1;
        if ($isunknown(select)) begin
            unk_exp = 16'h0000;
        end else begin
            unk_exp = onehot(int'(select));
        end
        compare16("unknown decoded_op", decoded_op, unk_exp);
        exp_q_fifo.push_back(unk_exp);
        @(posedge CLK);
        #1;
        check_output("unknown");

        // Sequence counter: clear, then count through T0..T15 and wrap to T0.
        apply_stimulus("seq_clear", 4'd9, 1'b1, 16'h0200, 16'h0000);
        cnt = 4'd0;
        for (int t = 0; t < 17; t++) begin
            apply_stimulus($sformatf("seq_T%0d", t % 16), cnt, 1'b0, onehot(t % 16), onehot(t % 16));
            cnt = cnt + 4'd1;
        end

        checks++;
        if (exp_q_fifo.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q_fifo.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
